// File: rtl/interrupt_timer.sv
// Bus-programmable down-counting interrupt timer with one-shot and auto-reload modes.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN (CTRL[15:8] = prescale value).
module interrupt_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        ctrl_wr;
  logic        preset_wr;
  logic        en_eff;
  logic [1:0]  mode_eff;
  logic        tick;

`ifdef TIMER_PRESCALE_EN
  logic [7:0]  scale_q, scale_d;
  logic [7:0]  psc_q, psc_d;
`endif

  // The FSM sees a CTRL write on the same edge, so enable/disable/mode take
  // effect on the writing edge itself rather than one cycle later.
  always_comb begin
    ctrl_wr   = we && (addr == 2'd0);
    preset_wr = we && (addr == 2'd1);
    en_eff    = ctrl_wr ? din[0]   : ctrl_q[0];
    mode_eff  = ctrl_wr ? din[2:1] : ctrl_q[2:1];
`ifdef TIMER_PRESCALE_EN
    tick      = (psc_q == scale_q);
`else
    tick      = 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    preset_d   = preset_wr ? din : preset_q;
`ifdef TIMER_PRESCALE_EN
    scale_d    = scale_q;
    psc_d      = psc_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef TIMER_PRESCALE_EN
        psc_d = '0;
`endif
        if (en_eff) state_d = LOAD;
      end
      LOAD: begin
`ifdef TIMER_PRESCALE_EN
        psc_d = '0;
`endif
        count_d = preset_q;
        state_d = en_eff ? CNT : IDLE;
      end
      CNT: begin
        if (!en_eff) begin
          state_d = IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          psc_d = tick ? '0 : psc_q + 8'd1;
`endif
          if (tick) begin
            if (count_q > 32'd1) begin
              count_d = count_q - 32'd1;
            end else begin
              count_d    = '0;
              irq_flag_d = 1'b1;
              state_d    = INT;
            end
          end
        end
      end
      INT: begin
        if (mode_eff == 2'b01) begin
          irq_flag_d = 1'b0;
          state_d    = LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A CTRL write overrides the FSM's enable clear and acknowledges the interrupt.
    if (ctrl_wr) begin
      ctrl_d     = din[3:0];
      irq_flag_d = 1'b0;
`ifdef TIMER_PRESCALE_EN
      scale_d    = din[15:8];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      scale_q    <= '0;
      psc_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
`ifdef TIMER_PRESCALE_EN
      scale_q    <= scale_d;
      psc_q      <= psc_d;
`endif
    end
  end

  always_comb begin
    unique case (addr)
`ifdef TIMER_PRESCALE_EN
      2'd0:    dout = {16'h0000, scale_q, 4'h0, ctrl_q};
`else
      2'd0:    dout = {28'h0000000, ctrl_q};
`endif
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = '0;
    endcase
  end

  assign irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_interrupt_timer.sv
// Directed self-checking bench for interrupt_timer (default build, prescaler off).
module tb_interrupt_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  interrupt_timer dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the next posedge, returns at the following negedge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    we   = 1'b1;
    din  = d;
    @(negedge clk);
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Auto-reload expectations for PRESET=3, one entry per cycle after the enabling write.
  logic [31:0] ar_count [10] = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0,
                                 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
  logic        ar_irq   [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    reset = 1'b1;
    addr  = 2'd0;
    we    = 1'b0;
    din   = '0;
    #1;
    check("rst_irq", {31'b0, irq}, 32'd0);
    rd("rst_ctrl", 2'd0, 32'h0);
    rd("rst_preset", 2'd1, 32'h0);
    rd("rst_count", 2'd2, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // One-shot, PRESET=5: irq rises 6 cycles after the enabling write and sticks.
    wr(2'd1, 32'd5);
    rd("os_preset", 2'd1, 32'd5);
    wr(2'd0, 32'h9);
    check("os_irq_c0", {31'b0, irq}, 32'd0);
    step(1);
    rd("os_count_c1", 2'd2, 32'd5);
    step(4);
    rd("os_count_c5", 2'd2, 32'd1);
    check("os_irq_c5", {31'b0, irq}, 32'd0);
    step(1);
    check("os_irq_c6", {31'b0, irq}, 32'd1);
    rd("os_count_c6", 2'd2, 32'd0);
    step(1);
    rd("os_ctrl_c7", 2'd0, 32'h8);
    step(3);
    check("os_irq_sticky", {31'b0, irq}, 32'd1);
    rd("os_count_end", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    check("os_irq_ack", {31'b0, irq}, 32'd0);

    // Auto-reload, PRESET=3: one-cycle pulse every 5 cycles.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("ar_irq_c%0d", i + 1), {31'b0, irq}, {31'b0, ar_irq[i]});
      rd($sformatf("ar_count_c%0d", i + 1), 2'd2, ar_count[i]);
    end
    wr(2'd0, 32'h0);
    step(2);
    check("ar_irq_off", {31'b0, irq}, 32'd0);

    // Masked, PRESET=2: flag sets silently, the FSM disables itself, then the ack write clears it.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("mk_irq_c%0d", i + 1), {31'b0, irq}, 32'd0);
    end
    rd("mk_ctrl", 2'd0, 32'h0);
    rd("mk_count", 2'd2, 32'd0);
    wr(2'd0, 32'h8);
    check("mk_irq_after_ack", {31'b0, irq}, 32'd0);
    step(2);
    check("mk_irq_later", {31'b0, irq}, 32'd0);

    // Disable mid-count at COUNT=6, with a PRESET write during CNT that must not disturb COUNT.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    step(2);
    rd("dm_count_c2", 2'd2, 32'd9);
    wr(2'd1, 32'd20);
    rd("dm_count_c3", 2'd2, 32'd8);
    step(2);
    rd("dm_count_c5", 2'd2, 32'd6);
    wr(2'd0, 32'h8);
    rd("dm_count_hold0", 2'd2, 32'd6);
    step(3);
    rd("dm_count_hold3", 2'd2, 32'd6);
    check("dm_irq", {31'b0, irq}, 32'd0);
    rd("dm_ctrl", 2'd0, 32'h8);
    wr(2'd0, 32'h9);
    step(1);
    rd("dm_reload", 2'd2, 32'd20);
    wr(2'd0, 32'h0);

    // PRESET=0 and PRESET=1 both enter INT on the first CNT cycle.
    for (int p = 0; p < 2; p++) begin
      wr(2'd1, p);
      wr(2'd0, 32'h9);
      step(1);
      check($sformatf("p%0d_irq_c1", p), {31'b0, irq}, 32'd0);
      step(1);
      check($sformatf("p%0d_irq_c2", p), {31'b0, irq}, 32'd1);
      rd($sformatf("p%0d_count_c2", p), 2'd2, 32'd0);
      wr(2'd0, 32'h8);
      check($sformatf("p%0d_ack", p), {31'b0, irq}, 32'd0);
    end

    // Mode 2 behaves as one-shot: sticky irq and self-clearing enable.
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hD);
    step(2);
    check("m2_irq_c2", {31'b0, irq}, 32'd1);
    step(1);
    rd("m2_ctrl", 2'd0, 32'hC);
    step(2);
    check("m2_irq_sticky", {31'b0, irq}, 32'd1);
    wr(2'd0, 32'h0);

    // Reserved/read-only locations and undefined CTRL bits.
    wr(2'd2, 32'h1234_5678);
    rd("ro_count", 2'd2, 32'd0);
    wr(2'd3, 32'hFFFF_FFFF);
    rd("rsv_read", 2'd3, 32'd0);
    wr(2'd0, 32'hFFFF_FFF0);
`ifdef TIMER_PRESCALE_EN
    rd("ctrl_upper", 2'd0, 32'h0000_FF00);
`else
    rd("ctrl_upper", 2'd0, 32'h0000_0000);
`endif
    wr(2'd0, 32'h0);

    // Asynchronous reset at COUNT=4 aborts the count before the next edge.
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h9);
    step(3);
    rd("ar_pre_count", 2'd2, 32'd4);
    #1;
    reset = 1'b1;
    rd("rst_async_count", 2'd2, 32'd0);
    check("rst_async_irq", {31'b0, irq}, 32'd0);
    @(negedge clk);
    rd("rst_async_ctrl", 2'd0, 32'h0);
    rd("rst_async_preset", 2'd1, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(5);
    rd("post_rst_count", 2'd2, 32'd0);
    rd("post_rst_ctrl", 2'd0, 32'h0);
    check("post_rst_irq", {31'b0, irq}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
